// File: rtl/bit_ram_arbiter.sv
// ----------------------------------------------------------------------------
// bit_ram_arbiter
//   Shares one single-bit RAM port between two requesters: requester 0
//   (pipeline) and requester 1 (peripheral/IO scanner). One transaction is
//   in flight at a time, sequenced by IDLE -> ISSUE -> (CAPTURE) -> ACK.
//
//   Configuration macro:
//     BIT_RAM_RR_EN  defined   -> round-robin arbitration on conflict
//                    undefined -> fixed priority, requester 0 wins
//
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     reqN/rwN/addrN/wdataN       requester N command (rw: 1=read, 0=write)
//     ackN                        one-cycle completion pulse to requester N
//     rdataN                      last bit read for requester N
//     bitRamEn/Rw/Addr/In         RAM command port (enable only in ISSUE)
//     bitRamOut                   RAM registered read data (Z when idle)
//     busy                        transaction in progress
//     gntId                       requester owning the current transaction
// ----------------------------------------------------------------------------
module bit_ram_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              wdata0,
    output logic              ack0,
    output logic              rdata0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              wdata1,
    output logic              ack1,
    output logic              rdata1,
    output logic              bitRamEn,
    output logic              bitRamRw,
    output logic [ADDR_W-1:0] bitRamAddr,
    output logic              bitRamIn,
    input  logic              bitRamOut,
    output logic              busy,
    output logic              gntId
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_req_any;
    logic                w_win;
    logic                w_grant;
    logic                r_gnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wdata;
    logic                r_rdata0;
    logic                r_rdata1;

    assign w_req_any = req0 | req1;
    assign w_grant   = (r_state == S_IDLE) && w_req_any;

`ifdef BIT_RAM_RR_EN
    // Remembers who was granted last; reset value 1 hands the first
    // conflict to requester 0.
    logic r_last;

    // Single request wins outright; on conflict the requester that was
    // not granted last wins.
    assign w_win = req0 ? (req1 ? ~r_last : 1'b0) : 1'b1;

    always_ff @(posedge clk) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_grant)
            r_last <= w_win;
    end
`else
    // Fixed priority: requester 0 wins whenever it asks.
    assign w_win = ~req0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_req_any) w_next = S_ISSUE;
            S_ISSUE:   w_next = r_rw ? S_CAPTURE : S_ACK;
            S_CAPTURE: w_next = S_ACK;
            S_ACK:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch: captured only at the grant, so the RAM command
    // outputs hold their last values outside ISSUE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt   <= 1'b0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= 1'b0;
        end else if (w_grant) begin
            r_gnt   <= w_win;
            r_rw    <= w_win ? rw1    : rw0;
            r_addr  <= w_win ? addr1  : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
        end
    end

    // ------------------------------------------------------------------
    // Read data: bitRamOut is only valid (non-Z) in CAPTURE, so it is
    // sampled there and nowhere else. Only the owner's bit is updated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata0 <= 1'b0;
            r_rdata1 <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            if (r_gnt)
                r_rdata1 <= bitRamOut;
            else
                r_rdata0 <= bitRamOut;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Enable is gated by reset combinationally so a reset landing in
    // ISSUE cannot complete a RAM write.
    assign bitRamEn   = (r_state == S_ISSUE) && !reset;
    assign bitRamRw   = r_rw;
    assign bitRamAddr = r_addr;
    assign bitRamIn   = r_wdata;

    assign ack0   = (r_state == S_ACK) && !r_gnt;
    assign ack1   = (r_state == S_ACK) &&  r_gnt;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign busy   = (r_state != S_IDLE);
    assign gntId  = r_gnt;

endmodule
